// File: rtl/tdm_demux1x2_rx.sv
// tdm_demux1x2_rx: rebuilds two W-bit channel words from a sync-framed, bit-interleaved
// 2-channel TDM stream and presents them together with a one-cycle valid strobe.
module tdm_demux1x2_rx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync,
  input  logic         d,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic         valid,
  output logic         busy,
  output logic         err
);
  localparam int CW = $clog2(2*W);
  localparam logic [CW-1:0] LAST = CW'(2*W-1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, y0_q, y0_d, y1_q, y1_d;
  logic valid_q, valid_d, err_q, err_d;
  logic start, step, last;
  always_comb begin
    start   = en && sync;
    step    = en && !sync && state_q == RECV;
    last    = step && cnt_q == LAST;
    state_d = start ? RECV : last ? IDLE : state_q;
    cnt_d   = start ? CW'(1) : last ? '0 : step ? cnt_q + CW'(1) : cnt_q;
    sh0_d   = start ? {{(W-1){1'b0}}, d} : step && !cnt_q[0] ? {sh0_q[W-2:0], d} : sh0_q;
    sh1_d   = start ? '0 : step && cnt_q[0] ? {sh1_q[W-2:0], d} : sh1_q;
    // The last bit is the ch1 LSB, so y1 takes the shifted value including it.
    y0_d    = last ? sh0_q : y0_q;
    y1_d    = last ? sh1_d : y1_q;
    valid_d = last;
    err_d   = start && state_q == RECV;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign y0    = y0_q;
  assign y1    = y1_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = state_q == RECV;
endmodule
